// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the fetch PC, fills a small in-order
// fetch buffer for decode, and handles redirects, ECALL halt and misaligned targets.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic [31:0] pcimm,
    input  logic        stall,
    input  logic [31:0] imem_inst,
    input  logic        dec_ready,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REDIRECT,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        halted_q;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   occ_q, occ_d;
    logic [31:0] buf_pc_q   [DEPTH];
    logic [31:0] buf_inst_q [DEPTH];

    logic empty, full, redirect, pop, push;

    assign empty    = (occ_q == '0);
    assign full     = (occ_q == (PW+1)'(DEPTH));
    // IDLE ignores redirects; everywhere else a redirect preempts all buffer activity.
    assign redirect = pc_src && (state_q != S_IDLE);
    assign pop      = !empty && dec_ready && !redirect;
    assign push     = (state_q == S_FETCH) && !stall && !pc_src && (!full || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        occ_d   = occ_q;
        if (redirect) begin
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
            if (pcimm[1:0] == 2'b00) begin
                pc_d    = pcimm;
                state_d = S_REDIRECT;
            end else begin
                err_d   = 1'b1;
                state_d = S_HALTED;
            end
        end else begin
            if (pop) rd_d = rd_q + PW'(1);
            if (push) begin
                wr_d  = wr_q + PW'(1);
                pc_d  = pc_q + 32'd4;
                cnt_d = cnt_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + (PW+1)'(1);
                2'b01:   occ_d = occ_q - (PW+1)'(1);
                default: occ_d = occ_q;
            endcase
            case (state_q)
                S_IDLE:     state_d = S_FETCH;
                S_FETCH:    if (push && imem_inst == ECALL) state_d = S_HALTED;
                S_REDIRECT: state_d = S_FETCH;
                default:    state_d = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            halted_q <= (state_d == S_HALTED);
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: the head outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_pc_q[wr_q]   <= pc_q;
            buf_inst_q[wr_q] <= imem_inst;
        end
    end

    assign pc           = pc_q;
    assign if_valid     = !empty;
    assign if_inst      = empty ? 32'd0 : buf_inst_q[rd_q];
    assign if_pc        = empty ? 32'd0 : buf_pc_q[rd_q];
    assign if_pc4       = empty ? 32'd0 : buf_pc_q[rd_q] + 32'd4;
    assign halted       = halted_q;
    assign misalign_err = err_q;
    assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed stimulus with a scoreboard of expected
// decode-side entries, checked by an independent monitor on every pop.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset, pc_src, stall, dec_ready;
    logic [31:0] pcimm, imem_inst;
    logic [31:0] pc, if_inst, if_pc, if_pc4, fetch_count;
    logic        if_valid, halted, misalign_err;

    logic        ecall_en;
    logic [31:0] ecall_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .pcimm(pcimm), .stall(stall),
        .imem_inst(imem_inst), .dec_ready(dec_ready), .pc(pc), .if_valid(if_valid),
        .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .halted(halted),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (ecall_en && a == ecall_addr) ? 32'h0000_0073 : (a | 32'h13);
    endfunction

    assign imem_inst = mem_word(pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Decode sees a sequential run of addresses from a start point until the next flush.
    task automatic load_seg(input logic [31:0] start);
        sb_q.delete();
        for (int i = 0; i < 24; i++)
            sb_q.push_back('{pc: start + 32'(4 * i), inst: mem_word(start + 32'(4 * i))});
    endtask

    always @(negedge clk) begin
        if (!reset && !pc_src && if_valid && dec_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, required no pop", if_pc, if_inst);
            end else begin
                mon_e = sb_q.pop_front();
                if (if_pc !== mon_e.pc || if_inst !== mon_e.inst || if_pc4 !== mon_e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL pop_entry: got pc=%h inst=%h pc4=%h, required pc=%h inst=%h pc4=%h",
                             if_pc, if_inst, if_pc4, mon_e.pc, mon_e.inst, mon_e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pc_src = 1'b0; pcimm = '0; stall = 1'b0; dec_ready = 1'b1;
        ecall_en = 1'b0; ecall_addr = 32'h10;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc4", if_pc4, 32'h0);

        // Streaming fetch after reset release
        load_seg(32'h0); reset = 1'b0;
        tick();
        chk("idle_valid", 32'(if_valid), 32'd0);
        chk("idle_pc", pc, 32'h0);
        tick();
        chk("first_push_valid", 32'(if_valid), 32'd1);
        chk("first_push_pc", pc, 32'h4);
        chk("first_push_count", fetch_count, 32'd1);
        tick(); tick();
        chk("three_push_pc", pc, 32'hC);
        chk("three_push_count", fetch_count, 32'd3);

        // Backpressure fills the buffer, then push and pop together
        reset = 1'b1; dec_ready = 1'b0;
        tick();
        load_seg(32'h0); reset = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("full_pc_hold", pc, 32'h8);
        chk("full_count", fetch_count, 32'd2);
        chk("full_head", if_pc, 32'h0);
        dec_ready = 1'b1;
        tick();
        chk("pushpop_pc", pc, 32'hC);
        chk("pushpop_head", if_pc, 32'h4);
        tick();
        chk("pushpop2_pc", pc, 32'h10);
        chk("pushpop2_count", fetch_count, 32'd4);
        dec_ready = 1'b0;
        tick();
        chk("still_full_pc", pc, 32'h10);

        // Redirect with a full buffer under stall
        stall = 1'b1; pc_src = 1'b1; pcimm = 32'h100; load_seg(32'h100);
        tick();
        chk("redir_flush_valid", 32'(if_valid), 32'd0);
        chk("redir_pc", pc, 32'h100);
        pc_src = 1'b0; stall = 1'b0; dec_ready = 1'b1;
        tick();
        chk("redir_cycle_pc", pc, 32'h100);
        chk("redir_cycle_valid", 32'(if_valid), 32'd0);
        tick();
        chk("redir_push_pc", pc, 32'h104);
        chk("redir_push_head", if_pc, 32'h100);
        chk("redir_push_count", fetch_count, 32'd5);
        stall = 1'b1;
        tick();
        chk("stall_pc", pc, 32'h104);
        chk("stall_count", fetch_count, 32'd5);
        chk("stall_drain", 32'(if_valid), 32'd0);
        tick();
        chk("stall_pc2", pc, 32'h104);
        stall = 1'b0;

        // ECALL at 0x10 halts fetch; a redirect resumes it
        reset = 1'b1; ecall_en = 1'b1;
        tick();
        load_seg(32'h0); reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("ecall_halted", 32'(halted), 32'd1);
        chk("ecall_pc", pc, 32'h14);
        chk("ecall_count", fetch_count, 32'd5);
        chk("ecall_head", if_inst, 32'h73);
        tick(); tick();
        chk("halt_drained", 32'(if_valid), 32'd0);
        chk("halt_pc", pc, 32'h14);
        chk("halt_count", fetch_count, 32'd5);
        pc_src = 1'b1; pcimm = 32'h40; load_seg(32'h40);
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_pc", pc, 32'h40);
        pc_src = 1'b0;
        tick();
        tick();
        chk("resume_push_pc", pc, 32'h44);
        chk("resume_push_head", if_pc, 32'h40);

        // Misaligned redirect
        dec_ready = 1'b0;
        tick(); tick();
        chk("pre_mis_pc", pc, 32'h48);
        pc_src = 1'b1; pcimm = 32'h102; sb_q.delete();
        tick();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_pc", pc, 32'h48);
        chk("mis_valid", 32'(if_valid), 32'd0);
        pc_src = 1'b0; dec_ready = 1'b1;
        tick(); tick();
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        chk("mis_pc_hold", pc, 32'h48);
        reset = 1'b1; ecall_en = 1'b0;
        tick();
        chk("mis_rst_err", 32'(misalign_err), 32'd0);
        chk("mis_rst_halted", 32'(halted), 32'd0);
        chk("mis_rst_pc", pc, 32'h0);

        // Reset during the redirect cycle
        load_seg(32'h0); reset = 1'b0;
        tick(); tick(); tick();
        pc_src = 1'b1; pcimm = 32'h200; load_seg(32'h200);
        tick();
        chk("pre_rst_redir_pc", pc, 32'h200);
        pc_src = 1'b0; reset = 1'b1; sb_q.delete();
        tick();
        chk("rst_redir_pc", pc, 32'h0);
        chk("rst_redir_valid", 32'(if_valid), 32'd0);
        chk("rst_redir_count", fetch_count, 32'd0);
        load_seg(32'h0); reset = 1'b0;
        tick();
        chk("rst_redir_idle_valid", 32'(if_valid), 32'd0);
        tick();
        chk("rst_redir_push_pc", pc, 32'h4);
        chk("rst_redir_push_valid", 32'(if_valid), 32'd1);

        // PC wraparound at the top of the address space
        pc_src = 1'b1; pcimm = 32'hFFFF_FFF8; load_seg(32'hFFFF_FFF8);
        tick();
        pc_src = 1'b0;
        tick(); tick(); tick();
        chk("wrap_pc", pc, 32'h0);
        tick();
        chk("wrap_pc4", pc, 32'h4);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: DEPTH, 2, fetch-buffer entries; power of two, >= 2.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: pc_src  in  1  taken branch/jump redirect request from execute.
REQ-006 Port: pcimm  in  32  redirect target, valid when pc_src=1.
REQ-007 Port: stall  in  1  hazard hold; blocks new fetches only.
REQ-008 Port: imem_inst  in  32  combinational instruction-memory read data at address pc.
REQ-009 Port: dec_ready  in  1  decode accepts the buffer head this cycle.
REQ-010 Port: pc  out  32  current fetch address driven to instruction memory.
REQ-011 Port: if_valid  out  1  buffer head valid to decode.
REQ-012 Port: if_inst, if_pc, if_pc4  out  32 each  head instruction, its address, address+4.
REQ-013 Port: halted  out  1  fetch stopped (ECALL fetched or misaligned target).
REQ-014 Port: misalign_err  out  1  sticky; set by a redirect with pcimm[1:0] != 0.
REQ-015 Port: fetch_count  out  32  instructions pushed since reset; wraps modulo 2^32.

Function
REQ-016 States SHALL be IDLE, FETCH, REDIRECT, HALTED; IDLE SHALL always go to FETCH on the next cycle.
REQ-017 Push condition: state=FETCH, stall=0, pc_src=0, and (buffer not full, or full with a pop this cycle); push writes {pc, imem_inst}, then pc <= pc+4, fetch_count += 1.
REQ-018 Pop: if_valid=1 and dec_ready=1 removes the head; if_valid SHALL equal (buffer not empty) and be independent of dec_ready.
REQ-019 A simultaneous push and pop on a full buffer SHALL keep the occupancy at DEPTH with no data loss; on an empty buffer, the pushed entry SHALL appear at the head one cycle later.
REQ-020 A pushed instruction equal to 32'h0000_0073 (ECALL) SHALL be stored, pc SHALL become pc+4, and the state SHALL become HALTED; HALTED performs no pushes and continues to drain pops.
REQ-021 pc_src=1 with pcimm[1:0]=0, in any non-IDLE state, SHALL flush the buffer, suppress push and pop that cycle, set pc <= pcimm, and move to REDIRECT.
REQ-022 REDIRECT SHALL last exactly one cycle with no push, then go to FETCH; pc_src=1 during REDIRECT SHALL restart the redirect to the new target.
REQ-023 pc_src=1 with pcimm[1:0] != 0 SHALL flush the buffer, hold pc, set misalign_err=1, and go to HALTED.
REQ-024 pc_src SHALL take priority over stall, push, pop and ECALL detection in the same cycle.
REQ-025 stall=1 SHALL hold pc and fetch_count; pops continue; stall has no effect outside FETCH.
REQ-026 if_pc4 SHALL equal if_pc+32'd4 with 32-bit wraparound; pc SHALL wrap from 32'hFFFF_FFFC to 0.
REQ-027 halted SHALL be 1 exactly while state=HALTED; leaving HALTED SHALL be possible only by a valid redirect or by reset.

Reset
REQ-028 reset=1 SHALL, at the next edge, set pc=RESET_PC, empty the buffer, set state=IDLE, and clear if_valid, halted, misalign_err and fetch_count; reset overrides all other inputs.
REQ-029 if_inst, if_pc and if_pc4 SHALL read 0 while the buffer is empty after reset.
REQ-030 Reset asserted mid-redirect or mid-halt SHALL discard that state; the first push SHALL occur 2 cycles after reset deasserts (IDLE, then FETCH).

Verification
REQ-031 Reset release, dec_ready=1, imem returns addr|0x13 -> pushes at pc 0,4,8; if_valid rises 1 cycle after the first push; fetch_count=3 after 3 pushes.
REQ-032 dec_ready=0 with DEPTH=2 -> 2 pushes then pc holds at 8; dec_ready=1 -> simultaneous push/pop, occupancy stays at 2.
REQ-033 pc_src=1, pcimm=0x100, while the buffer holds 2 entries and stall=1 -> buffer empty next cycle, pc=0x100, one REDIRECT cycle, next push has if_pc=0x100.
REQ-034 imem_inst=0x00000073 at pc=0x10 -> the entry is pushed, pc=0x14, halted=1, buffer drains; a later pc_src to 0x40 -> halted=0, fetch resumes at 0x40.
REQ-035 pc_src=1, pcimm=0x102 -> misalign_err=1, halted=1, pc unchanged, buffer empty; reset clears both.
REQ-036 Reset asserted during REDIRECT -> pc=RESET_PC, if_valid=0, first push 2 cycles after release.
